fpu_wb_arbiter: RTL and testbench

//  Merges the two FP result sources onto the single write port (we/addr/data) of the FP register file.

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fpu_wb_fifo.sv | 79 +++++++
 rtl/fpu_wb_arbiter.sv | 90 +++++++++
 tb/tb_fpu_wb_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP writeback path.
package fpu_pkg;
  localparam int FPU_FLEN = 64;
  localparam int NFREG    = 32;

  typedef struct packed {
    logic [4:0]          rd;
    logic [FPU_FLEN-1:0] res;
  } fwb_entry_t;

  function automatic logic [NFREG-1:0] rd_bit(input logic [4:0] rd);
    rd_bit     = '0;
    rd_bit[rd] = 1'b1;
  endfunction
endpackage

// File: rtl/fpu_wb_fifo.sv
// Circular buffer of queued div/sqrt results; each slot carries a valid bit so
// entries overwritten by a younger pipeline write can be killed in place.
module fpu_wb_fifo #(
  parameter int FLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [4:0]           push_rd,
  input  logic [FLEN-1:0]      push_res,
  input  logic                 pop,
  input  logic                 squash_en,
  input  logic [4:0]           squash_rd,
  output logic [4:0]           head_rd,
  output logic [FLEN-1:0]      head_res,
  output logic                 head_vld,
  output logic                 full,
  output logic                 empty,
  output logic [5*DEPTH-1:0]   ent_rd,
  output logic [DEPTH-1:0]     ent_vld
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [4:0]      rd_q  [DEPTH];
  logic [FLEN-1:0] res_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_rd  = rd_q[rd_ptr];
  assign head_res = res_q[rd_ptr];
  assign head_vld = vld_q[rd_ptr];
  assign ent_vld  = vld_q;

  always_comb begin
    ent_rd = '0;
    for (int i = 0; i < DEPTH; i++) ent_rd[5*i +: 5] = rd_q[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      // Kill older queued writes to the same register; the slot stays occupied.
      for (int i = 0; i < DEPTH; i++)
        if (squash_en && vld_q[i] && rd_q[i] == squash_rd) vld_q[i] <= 1'b0;
      if (do_pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        rd_q[wr_ptr]  <= push_rd;
        res_q[wr_ptr] <= push_res;
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fpu_wb_arbiter.sv
// Merges pipeline writeback and div/sqrt results onto the FP regfile write port.
// Pipeline wins; div results bypass when idle or queue until the port frees up.
module fpu_wb_arbiter
  import fpu_pkg::*;
#(
  parameter int FLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             PipeWe,
  input  logic [4:0]       PipeRd,
  input  logic [FLEN-1:0]  PipeRes,
  input  logic             DivValid,
  input  logic [4:0]       DivRd,
  input  logic [FLEN-1:0]  DivRes,
  output logic             DivReady,
  output logic             WbWe,
  output logic [4:0]       WbAdr,
  output logic [FLEN-1:0]  WbData,
  output logic [31:0]      PendMask,
  output logic             Squash
);
  // Handshake: a div result transfers on a cycle with DivValid & DivReady; DivReady
  // depends only on queue occupancy. The pipeline side has no backpressure.
  logic [4:0]         head_rd;
  logic [FLEN-1:0]    head_res;
  logic               head_vld, fifo_full, fifo_empty;
  logic [5*DEPTH-1:0] ent_rd;
  logic [DEPTH-1:0]   ent_vld;
  logic               bypass, push, pop;

  assign DivReady = ~fifo_full;
  assign bypass   = ~PipeWe & fifo_empty & DivValid;
  assign pop      = ~PipeWe & ~fifo_empty;
  assign push     = DivValid & ~fifo_full & ~bypass;

  fpu_wb_fifo #(.FLEN(FLEN), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_rd   (DivRd),
    .push_res  (DivRes),
    .pop       (pop),
    .squash_en (PipeWe),
    .squash_rd (PipeRd),
    .head_rd   (head_rd),
    .head_res  (head_res),
    .head_vld  (head_vld),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_rd    (ent_rd),
    .ent_vld   (ent_vld)
  );

  // Regfile samples on negedge, so this mux uses only state and inputs.
  always_comb begin
    WbWe   = 1'b0;
    WbAdr  = '0;
    WbData = '0;
    if (reset_n) begin
      if (PipeWe) begin
        WbWe   = 1'b1;
        WbAdr  = PipeRd;
        WbData = PipeRes;
      end else if (!fifo_empty) begin
        if (head_vld) begin
          WbWe   = 1'b1;
          WbAdr  = head_rd;
          WbData = head_res;
        end
      end else if (DivValid) begin
        WbWe   = 1'b1;
        WbAdr  = DivRd;
        WbData = DivRes;
      end
    end
  end

  always_comb begin
    PendMask = '0;
    Squash   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) begin
        PendMask = PendMask | rd_bit(ent_rd[5*i +: 5]);
        if (PipeWe && ent_rd[5*i +: 5] == PipeRd) Squash = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Bench for fpu_wb_arbiter: directed vector table, reset sequences, random traffic
// against a queue-based reference model.
module tb_fpu_wb_arbiter;
  import fpu_pkg::*;

  localparam int FLEN  = 64;
  localparam int DEPTH = 2;
  localparam int W     = 1 + $bits(fwb_entry_t);

  logic            clk = 1'b0;
  logic            reset_n;
  logic            PipeWe, DivValid;
  logic [4:0]      PipeRd, DivRd;
  logic [FLEN-1:0] PipeRes, DivRes;
  logic            DivReady, WbWe, Squash;
  logic [4:0]      WbAdr;
  logic [FLEN-1:0] WbData;
  logic [31:0]     PendMask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpu_wb_arbiter #(.FLEN(FLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .PipeWe(PipeWe), .PipeRd(PipeRd), .PipeRes(PipeRes),
    .DivValid(DivValid), .DivRd(DivRd), .DivRes(DivRes),
    .DivReady(DivReady), .WbWe(WbWe), .WbAdr(WbAdr), .WbData(WbData),
    .PendMask(PendMask), .Squash(Squash)
  );

  // Reference model: queue of {valid, rd, res}, oldest at the front.
  logic [W-1:0] exp_q[$];
  logic        m_we, m_ready, m_sq, m_pop, m_push;
  logic [4:0]  m_adr;
  logic [63:0] m_data;
  logic [31:0] m_pend;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_eval();
    fwb_entry_t e;
    logic bypass;
    bypass  = 1'b0;
    m_pop   = 1'b0;
    m_we    = 1'b0;
    m_adr   = '0;
    m_data  = '0;
    m_ready = (exp_q.size() < DEPTH);
    m_pend  = '0;
    m_sq    = 1'b0;
    foreach (exp_q[i]) begin
      e = exp_q[i][W-2:0];
      if (exp_q[i][W-1]) begin
        m_pend = m_pend | (32'd1 << e.rd);
        if (PipeWe && e.rd == PipeRd) m_sq = 1'b1;
      end
    end
    if (PipeWe) begin
      m_we = 1'b1; m_adr = PipeRd; m_data = PipeRes;
    end else if (exp_q.size() > 0) begin
      e = exp_q[0][W-2:0];
      m_pop = 1'b1;
      m_we  = exp_q[0][W-1];
      m_adr = e.rd; m_data = e.res;
    end else if (DivValid) begin
      bypass = 1'b1;
      m_we = 1'b1; m_adr = DivRd; m_data = DivRes;
    end
    m_push = DivValid && m_ready && !bypass;
  endtask

  task automatic model_update();
    fwb_entry_t e;
    if (!reset_n) return;
    if (PipeWe)
      foreach (exp_q[i]) begin
        e = exp_q[i][W-2:0];
        if (e.rd == PipeRd) exp_q[i][W-1] = 1'b0;
      end
    if (m_pop) void'(exp_q.pop_front());
    if (m_push) begin
      e.rd = DivRd; e.res = DivRes;
      exp_q.push_back({1'b1, e});
    end
  endtask

  task automatic drive(input logic pw, input logic [4:0] prd, input logic [63:0] pres,
                       input logic dv, input logic [4:0] drd, input logic [63:0] dres);
    PipeWe = pw; PipeRd = prd; PipeRes = pres;
    DivValid = dv; DivRd = drd; DivRes = dres;
    #2;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".we"}, WbWe, m_we);
    if (m_we) begin
      chk({tag, ".adr"}, WbAdr, m_adr);
      chk({tag, ".data"}, WbData, m_data);
    end
    chk({tag, ".ready"}, DivReady, m_ready);
    chk({tag, ".pend"}, PendMask, m_pend);
    chk({tag, ".squash"}, Squash, m_sq);
  endtask

  typedef struct {
    logic        pw;  logic [4:0] prd; logic [63:0] pres;
    logic        dv;  logic [4:0] drd; logic [63:0] dres;
    logic        we;  logic [4:0] adr; logic [63:0] data;
    logic        ready; logic [31:0] pend; logic sq;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic pw, input logic [4:0] prd, input logic [63:0] pres,
                              input logic dv, input logic [4:0] drd, input logic [63:0] dres,
                              input logic we, input logic [4:0] adr, input logic [63:0] data,
                              input logic ready, input logic [31:0] pend, input logic sq);
    vec_t v;
    v.pw = pw; v.prd = prd; v.pres = pres; v.dv = dv; v.drd = drd; v.dres = dres;
    v.we = we; v.adr = adr; v.data = data; v.ready = ready; v.pend = pend; v.sq = sq;
    return v;
  endfunction

  initial begin
    // bypass
    vecs[0]  = mk(0, 0, 0, 1, 5, 64'h4000_0000_0000_0000, 1, 5, 64'h4000_0000_0000_0000, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0,                       0, 0, 0, 1, 0, 0);
    // collision
    vecs[2]  = mk(1, 3, 64'hA3, 1, 7, 64'hB7,  1, 3, 64'hA3, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0,            1, 7, 64'hB7, 1, 32'h80, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0);
    // full queue under sustained pipeline writes
    vecs[5]  = mk(1, 1, 64'hC1, 1, 10, 64'hD10, 1, 1, 64'hC1, 1, 0, 0);
    vecs[6]  = mk(1, 2, 64'hC2, 1, 11, 64'hD11, 1, 2, 64'hC2, 1, 32'h400, 0);
    vecs[7]  = mk(1, 4, 64'hC4, 1, 12, 64'hD12, 1, 4, 64'hC4, 0, 32'hC00, 0);
    vecs[8]  = mk(1, 6, 64'hC6, 0, 0, 0,        1, 6, 64'hC6, 0, 32'hC00, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0,             1, 10, 64'hD10, 0, 32'hC00, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0,             1, 11, 64'hD11, 1, 32'h800, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0,             0, 0, 0, 1, 0, 0);
    // WAW squash
    vecs[12] = mk(1, 8, 64'hF8, 1, 9, 64'hE9,  1, 8, 64'hF8, 1, 0, 0);
    vecs[13] = mk(1, 9, 64'h99, 0, 0, 0,       1, 9, 64'h99, 1, 32'h200, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0);
    // same-cycle push with matching rd is not squashed
    vecs[16] = mk(1, 13, 64'h1313, 1, 13, 64'h7777, 1, 13, 64'h1313, 1, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0,               1, 13, 64'h7777, 1, 32'h2000, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0,               0, 0, 0, 1, 0, 0);

    // Reset held with a div result offered
    reset_n = 1'b0;
    PipeWe = 0; PipeRd = 0; PipeRes = 0;
    DivValid = 1; DivRd = 2; DivRes = 64'h2222;
    #12;
    chk("rst.we", WbWe, 0);
    chk("rst.adr", WbAdr, 0);
    chk("rst.data", WbData, 0);
    chk("rst.ready", DivReady, 1);
    chk("rst.pend", PendMask, 0);
    chk("rst.squash", Squash, 0);
    #6 reset_n = 1'b1;
    drive(0, 0, 0, 1, 2, 64'h2222);
    chk("rel.we", WbWe, 1);
    chk("rel.adr", WbAdr, 2);
    check_model("rel");
    tick();

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].pw, vecs[i].prd, vecs[i].pres, vecs[i].dv, vecs[i].drd, vecs[i].dres);
      chk($sformatf("v%0d.we", i), WbWe, vecs[i].we);
      if (vecs[i].we) begin
        chk($sformatf("v%0d.adr", i), WbAdr, vecs[i].adr);
        chk($sformatf("v%0d.data", i), WbData, vecs[i].data);
      end
      chk($sformatf("v%0d.ready", i), DivReady, vecs[i].ready);
      chk($sformatf("v%0d.pend", i), PendMask, vecs[i].pend);
      chk($sformatf("v%0d.squash", i), Squash, vecs[i].sq);
      tick();
    end

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    // Async reset with two queued entries
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(1, 1, 64'h11, 1, 20, 64'h2020);
    tick();
    drive(1, 2, 64'h12, 1, 21, 64'h2121);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_rst.pend", PendMask, 32'h0030_0000);
    reset_n = 1'b0;
    #1;
    chk("arst.we", WbWe, 0);
    chk("arst.pend", PendMask, 0);
    chk("arst.ready", DivReady, 1);
    chk("arst.squash", Squash, 0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    chk("no_stale.we", WbWe, 0);
    check_model("post_rst");
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check_model("post_rst2");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
